// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
// Imported by serial_addsub_ctrl.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_fa.sv
// Combinational 1-bit full adder cell.
// serial_addsub_ctrl time-multiplexes a single instance of it across every bit position.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full-adder cell, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_start,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_result,
    output logic             out_co
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             carry_reg, carry_next;
    logic             op_reg, op_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             co_reg, co_next;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_reg, ovf_next;
`endif

    logic             fa_a, fa_b, fa_cin, fa_s, fa_cout;
    logic [WIDTH-1:0] sum_shift;

    // Operands are shifted right so the active bit always sits at position 0.
    assign fa_a   = a_sh_reg[0];
    assign fa_b   = b_sh_reg[0] ^ op_reg;
    assign fa_cin = carry_reg;

    serial_fa_cell u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (fa_cin),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
    assign sum_shift = (shift_reg >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        carry_next  = carry_reg;
        op_next     = op_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        shift_next  = shift_reg;
        result_next = result_reg;
        co_next     = co_reg;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_next    = ovf_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (in_start) begin
                    a_sh_next  = in_a;
                    b_sh_next  = in_b;
                    op_next    = in_op;
                    cnt_next   = '0;
                    carry_next = in_op;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                shift_next = sum_shift;
                a_sh_next  = a_sh_reg >> 1;
                b_sh_next  = b_sh_reg >> 1;
                carry_next = fa_cout;
                cnt_next   = cnt_reg + CW'(1);
                if (cnt_reg == CNT_LAST) begin
                    // Publish on the final bit so the result is valid alongside done.
                    result_next = sum_shift;
                    co_next     = fa_cout ^ (op_reg == OP_SUB);
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_next    = carry_reg ^ fa_cout;
`endif
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            op_reg     <= OP_ADD;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            shift_reg  <= '0;
            result_reg <= '0;
            co_reg     <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            carry_reg  <= carry_next;
            op_reg     <= op_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            shift_reg  <= shift_next;
            result_reg <= result_next;
            co_reg     <= co_next;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_reg    <= ovf_next;
`endif
        end
    end

    assign out_busy   = (state_reg == ST_RUN);
    assign out_done   = (state_reg == ST_DONE);
    assign out_result = result_reg;
    assign out_co     = co_reg;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign out_ovf    = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed, table-driven bench for serial_addsub_ctrl at WIDTH=8.
// Checks out_ovf as well when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ovf;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             in_start;
    logic             in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_busy;
    logic             out_done;
    logic [WIDTH-1:0] out_result;
    logic             out_co;
    logic             out_ovf;

    int tests = 0;
    int fails = 0;
    logic [WIDTH-1:0] hold_r;
    logic             hold_co;
    logic             hold_ovf;

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .in_clk     (clk),
        .in_rst_n   (rst_n),
        .in_start   (in_start),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_busy   (out_busy),
        .out_done   (out_done),
        .out_result (out_result),
        .out_co     (out_co)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .out_ovf    (out_ovf)
`endif
    );

`ifndef SERIAL_ADDSUB_OVF_EN
    assign out_ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ovf(input string name, input logic exp);
`ifdef SERIAL_ADDSUB_OVF_EN
        check(name, 32'(out_ovf), 32'(exp));
`endif
    endtask

    // Start at edge 0, then check busy/done/result on every cycle through WIDTH+2.
    task automatic run_op(input vec_t v);
        @(negedge clk);
        in_start = 1'b1;
        in_op    = v.op;
        in_a     = v.a;
        in_b     = v.b;
        for (int c = 1; c <= WIDTH + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                in_start = 1'b0;
                in_a     = ~v.a;
                in_b     = ~v.b;
                in_op    = ~v.op;
            end
            check("busy", 32'(out_busy), 32'(c <= WIDTH));
            check("done", 32'(out_done), 32'(c == WIDTH + 1));
            if (c <= WIDTH) begin
                check("result_hold", 32'(out_result), 32'(hold_r));
                check("co_hold", 32'(out_co), 32'(hold_co));
            end else begin
                check("result", 32'(out_result), 32'(v.res));
                check("co", 32'(out_co), 32'(v.co));
                check_ovf("ovf", v.ovf);
            end
        end
        hold_r   = v.res;
        hold_co  = v.co;
        hold_ovf = v.ovf;
        $display("[TB] %s a=0x%02h b=0x%02h -> result=0x%02h co=%0b ovf=%0b",
                 v.op ? "sub" : "add", v.a, v.b, out_result, out_co, out_ovf);
    endtask

    vec_t vecs[11];
    int   done_cnt;

    initial begin
        vecs[0]  = '{1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};

        rst_n    = 1'b0;
        in_start = 1'b0;
        in_op    = 1'b0;
        in_a     = '0;
        in_b     = '0;
        hold_r   = '0;
        hold_co  = 1'b0;
        hold_ovf = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_done", 32'(out_done), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_co", 32'(out_co), 32'd0);
        check_ovf("rst_ovf", 1'b0);
        rst_n = 1'b1;

        // Start re-pulsed during RUN (cycle 3) and DONE (cycle 9) must be ignored.
        @(negedge clk);
        in_start = 1'b1;
        in_op    = 1'b0;
        in_a     = 8'h3C;
        in_b     = 8'h05;
        done_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (out_done) done_cnt++;
            if (c == 1 || c == 4 || c == 10) in_start = 1'b0;
            if (c == 3 || c == 9) begin
                in_start = 1'b1;
                in_op    = 1'b1;
                in_a     = 8'hAA;
                in_b     = 8'h11;
            end
            if (c == 9) begin
                check("repulse_result", 32'(out_result), 32'h41);
                check("repulse_co", 32'(out_co), 32'd0);
            end
            if (c >= 10) begin
                check("repulse_busy", 32'(out_busy), 32'd0);
                check("repulse_hold", 32'(out_result), 32'h41);
            end
        end
        check("repulse_done_count", 32'(done_cnt), 32'd1);
        hold_r   = 8'h41;
        hold_co  = 1'b0;
        hold_ovf = 1'b0;
        $display("[TB] repulse add a=0x3C b=0x05 -> result=0x%02h dones=%0d", out_result, done_cnt);

        for (int i = 0; i < 11; i++) run_op(vecs[i]);

        // Reset asserted mid-run discards the operation and clears the held result.
        @(negedge clk);
        in_start = 1'b1;
        in_op    = 1'b0;
        in_a     = 8'h12;
        in_b     = 8'h34;
        done_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) in_start = 1'b0;
            if (c == 4) rst_n = 1'b0;
            if (c == 5) begin
                check("midrst_busy", 32'(out_busy), 32'd0);
                check("midrst_done", 32'(out_done), 32'd0);
                check("midrst_result", 32'(out_result), 32'd0);
                check("midrst_co", 32'(out_co), 32'd0);
                check_ovf("midrst_ovf", 1'b0);
                rst_n = 1'b1;
            end
            if (c > 5 && out_done) done_cnt++;
            if (c > 5) check("midrst_idle_busy", 32'(out_busy), 32'd0);
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        hold_r   = '0;
        hold_co  = 1'b0;
        hold_ovf = 1'b0;
        $display("[TB] reset mid-run add a=0x12 b=0x34 -> result=0x%02h dones=%0d", out_result, done_cnt);

        run_op(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
